// File: rtl/guitar_pkg.sv
// Shared note encodings, frequencies and period helpers used by the tone
// generator and the tone decoder so both sides agree on every period.
package guitar_pkg;

  localparam int unsigned CLK_HZ    = 25_000_000;
  localparam int unsigned NUM_NOTES = 7;

  typedef enum logic [2:0] {
    NOTE_A = 3'd0,
    NOTE_B = 3'd1,
    NOTE_C = 3'd2,
    NOTE_D = 3'd3,
    NOTE_E = 3'd4,
    NOTE_F = 3'd5,
    NOTE_G = 3'd6
  } note_e;

  typedef enum logic {
    DEC_SILENT,
    DEC_MEASURE
  } dec_state_e;

  localparam int unsigned FREQ_A = 220;
  localparam int unsigned FREQ_B = 247;
  localparam int unsigned FREQ_C = 261;
  localparam int unsigned FREQ_D = 294;
  localparam int unsigned FREQ_E = 330;
  localparam int unsigned FREQ_F = 349;
  localparam int unsigned FREQ_G = 392;

  function automatic int unsigned note_freq(input int unsigned idx);
    case (idx)
      0:       return FREQ_A;
      1:       return FREQ_B;
      2:       return FREQ_C;
      3:       return FREQ_D;
      4:       return FREQ_E;
      5:       return FREQ_F;
      6:       return FREQ_G;
      default: return FREQ_A;
    endcase
  endfunction

  // Matches the generator's toggle scheme: even period, half rounded up by one.
  function automatic int unsigned nominal_period(input int unsigned clk_hz,
                                                 input int unsigned freq);
    return 2 * ((clk_hz / freq) / 2 + 1);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous line followed by a one-cycle
// rising-edge detector.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/tone_decoder.sv
// Decodes which note (A..G) a square-wave line carries by timing rising edges
// and locking after LOCK_COUNT consecutive periods matching one nominal period.
module tone_decoder #(
  parameter int unsigned CLK_HZ     = guitar_pkg::CLK_HZ,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned TOL        = 1024,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned TIMEOUT    = 262144
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sound_in,
  output logic [2:0] note,
  output logic       note_valid,
  output logic       note_changed
);

  import guitar_pkg::*;

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

  dec_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MW-1:0]    match_q, match_d;
  logic [2:0]       last_cand_q, last_cand_d;
  logic             last_ok_q, last_ok_d;
  logic [2:0]       note_q, note_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;

  logic             rise;
  logic [2:0]       cand;
  logic             cand_valid;
  logic [CNT_W-1:0] nom;
  logic [CNT_W-1:0] diff;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sound_in),
    .rise_o(rise)
  );

  // Windows are disjoint for a legal TOL, so first-hit priority only matters
  // for misconfigured parameters.
  always_comb begin
    cand       = NOTE_A;
    cand_valid = 1'b0;
    nom        = '0;
    diff       = '0;
    for (int unsigned i = 0; i < NUM_NOTES; i++) begin
      nom  = CNT_W'(nominal_period(CLK_HZ, note_freq(i)));
      diff = (cnt_q >= nom) ? (cnt_q - nom) : (nom - cnt_q);
      if (!cand_valid && (diff <= CNT_W'(TOL))) begin
        cand_valid = 1'b1;
        cand       = 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    match_d     = match_q;
    last_cand_d = last_cand_q;
    last_ok_d   = last_ok_q;
    note_d      = note_q;
    valid_d     = valid_q;
    changed_d   = 1'b0;
    case (state_q)
      DEC_SILENT: begin
        cnt_d = '0;
        if (rise) begin
          cnt_d   = CNT_W'(1);
          state_d = DEC_MEASURE;
        end
      end
      DEC_MEASURE: begin
        // Timeout takes precedence over a coincident rise, which is dropped.
        if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d   = DEC_SILENT;
          cnt_d     = '0;
          valid_d   = 1'b0;
          match_d   = '0;
          last_ok_d = 1'b0;
        end else if (rise) begin
          cnt_d = CNT_W'(1);
          if (!cand_valid) begin
            match_d = '0;
          end else if (last_ok_q && (cand == last_cand_q)) begin
            match_d = (match_q == MW'(LOCK_COUNT)) ? match_q : match_q + MW'(1);
          end else begin
            match_d = MW'(1);
          end
          last_cand_d = cand;
          last_ok_d   = cand_valid;
          if (cand_valid && (match_d == MW'(LOCK_COUNT)) &&
              (!valid_q || (note_q != cand))) begin
            note_d    = cand;
            valid_d   = 1'b1;
            changed_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = DEC_SILENT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= DEC_SILENT;
      cnt_q       <= '0;
      match_q     <= '0;
      last_cand_q <= '0;
      last_ok_q   <= 1'b0;
      note_q      <= '0;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      last_cand_q <= last_cand_d;
      last_ok_q   <= last_ok_d;
      note_q      <= note_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
    end
  end

  assign note         = note_q;
  assign note_valid   = valid_q;
  assign note_changed = changed_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder at a scaled-down clock rate so that note
// periods stay around a thousand cycles.
module tb_tone_decoder;

  // At 250 kHz: A=1138 B=1014 C=958 D=852 E=758 F=718 G=638 cycles.
  localparam int unsigned CLK_HZ     = 250_000;
  localparam int unsigned CNT_W      = 12;
  localparam int unsigned TOL        = 10;
  localparam int unsigned LOCK_COUNT = 3;
  localparam int unsigned TIMEOUT    = 2048;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sound_in;
  logic [2:0] note;
  logic       note_valid;
  logic       note_changed;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int base   = 0;

  tone_decoder #(
    .CLK_HZ    (CLK_HZ),
    .CNT_W     (CNT_W),
    .TOL       (TOL),
    .LOCK_COUNT(LOCK_COUNT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sound_in    (sound_in),
    .note        (note),
    .note_valid  (note_valid),
    .note_changed(note_changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (note_changed === 1'b1) pulses++;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic period(input int unsigned hi, input int unsigned lo);
    sound_in = 1'b1;
    step(hi);
    sound_in = 1'b0;
    step(lo);
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    sound_in = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      sound_in = ~sound_in;
      step(1);
      checks++;
      if ({note, note_valid, note_changed} !== 5'b0) begin
        $display("FAIL reset_hold cyc%0d: note=%0d valid=%b changed=%b, expected 0/0/0",
                 i, note, note_valid, note_changed);
        errors++;
      end
    end
    sound_in = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    checks++;
    if ({note, note_valid, note_changed} !== 5'b0) begin
      $display("FAIL reset_release: note=%0d valid=%b changed=%b, expected 0/0/0",
               note, note_valid, note_changed);
      errors++;
    end
  endtask

  task automatic test_lock_a;
    base = pulses;
    repeat (3) period(569, 569);
    sound_in = 1'b1;
    step(2);
    checks++;
    if ({note_valid, note_changed} !== 2'b00) begin
      $display("FAIL lock_a_early: valid=%b changed=%b, expected 0/0", note_valid, note_changed);
      errors++;
    end
    step(1);
    checks++;
    if ({note, note_valid, note_changed} !== {3'd0, 1'b1, 1'b1}) begin
      $display("FAIL lock_a: note=%0d valid=%b changed=%b, expected 0/1/1",
               note, note_valid, note_changed);
      errors++;
    end
    step(566);
    sound_in = 1'b0;
    step(569);
    checks++;
    if (pulses - base !== 1) begin
      $display("FAIL lock_a_pulses: got %0d, expected 1", pulses - base);
      errors++;
    end
  endtask

  task automatic test_change_g;
    base = pulses;
    for (int i = 0; i < 4; i++) begin
      period(319, 319);
      checks++;
      if (note_valid !== 1'b1) begin
        $display("FAIL change_g_valid p%0d: got %b, expected 1", i, note_valid);
        errors++;
      end
      if (i == 2) begin
        checks++;
        if (note !== 3'd0) begin
          $display("FAIL change_g_before: note=%0d, expected 0", note);
          errors++;
        end
      end
    end
    checks++;
    if (note !== 3'd6 || pulses - base !== 1) begin
      $display("FAIL change_g: note=%0d pulses=%0d, expected 6 and 1", note, pulses - base);
      errors++;
    end
  endtask

  task automatic test_off_table;
    base = pulses;
    repeat (4) period(450, 450);
    checks++;
    if ({note, note_valid} !== {3'd6, 1'b1} || pulses != base) begin
      $display("FAIL off_table: note=%0d valid=%b pulses=%0d, expected 6/1/0",
               note, note_valid, pulses - base);
      errors++;
    end
    repeat (5) period(575, 574);
    checks++;
    if ({note, note_valid} !== {3'd6, 1'b1} || pulses != base) begin
      $display("FAIL tol_over: note=%0d valid=%b pulses=%0d, expected 6/1/0",
               note, note_valid, pulses - base);
      errors++;
    end
    repeat (3) period(574, 574);
    checks++;
    if (note !== 3'd6) begin
      $display("FAIL tol_edge_early: note=%0d, expected 6", note);
      errors++;
    end
    period(574, 574);
    checks++;
    if ({note, note_valid} !== {3'd0, 1'b1} || pulses - base !== 1) begin
      $display("FAIL tol_edge_lock: note=%0d valid=%b pulses=%0d, expected 0/1/1",
               note, note_valid, pulses - base);
      errors++;
    end
  endtask

  task automatic test_timeout;
    base = pulses;
    repeat (3) period(379, 379);
    sound_in = 1'b1;
    step(3);
    checks++;
    if ({note, note_valid, note_changed} !== {3'd4, 1'b1, 1'b1}) begin
      $display("FAIL lock_e: note=%0d valid=%b changed=%b, expected 4/1/1",
               note, note_valid, note_changed);
      errors++;
    end
    step(376);
    sound_in = 1'b0;
    step(TIMEOUT - 1 - 376);
    checks++;
    if (note_valid !== 1'b1) begin
      $display("FAIL timeout_early: valid=%b, expected 1", note_valid);
      errors++;
    end
    step(1);
    checks++;
    if ({note, note_valid, note_changed} !== {3'd4, 1'b0, 1'b0}) begin
      $display("FAIL timeout: note=%0d valid=%b changed=%b, expected 4/0/0",
               note, note_valid, note_changed);
      errors++;
    end
    step(5);
    checks++;
    if (pulses - base !== 1) begin
      $display("FAIL timeout_pulses: got %0d, expected 1", pulses - base);
      errors++;
    end
  endtask

  task automatic test_reset_mid;
    base = pulses;
    repeat (3) period(426, 426);
    rst_n = 1'b0;
    step(1);
    checks++;
    if ({note, note_valid, note_changed} !== 5'b0) begin
      $display("FAIL reset_mid: note=%0d valid=%b changed=%b, expected 0/0/0",
               note, note_valid, note_changed);
      errors++;
    end
    rst_n = 1'b1;
    repeat (3) period(426, 426);
    checks++;
    if ({note, note_valid} !== {3'd0, 1'b0}) begin
      $display("FAIL reset_mid_early: note=%0d valid=%b, expected 0/0", note, note_valid);
      errors++;
    end
    period(426, 426);
    checks++;
    if ({note, note_valid} !== {3'd3, 1'b1} || pulses - base !== 1) begin
      $display("FAIL reset_mid_lock: note=%0d valid=%b pulses=%0d, expected 3/1/1",
               note, note_valid, pulses - base);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_lock_a();
    test_change_g();
    test_off_table();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
